// File: rtl/fpu_fir_seq_pkg.sv
// Shared FPU types (float16, FPU_opcode) and the FIR sequencer state enum.
// FPU_FIR_ZERO_EN adds helpers that treat 0x0000 as an exact zero around the FPU.
package fpu_fir_seq_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mantis;
  } float16;

  typedef enum logic {
    ADD  = 1'b0,
    MULT = 1'b1
  } FPU_opcode;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } fir_state_t;

  localparam float16 F16_ZERO = 16'h0000;

`ifdef FPU_FIR_ZERO_EN
  // The FPU has no zero encoding, so exact zeros are resolved here instead.
  function automatic float16 zero_mul(input float16 a, input float16 b, input float16 r);
    if ((a == F16_ZERO) || (b == F16_ZERO)) return F16_ZERO;
    else return r;
  endfunction

  function automatic float16 zero_add(input float16 a, input float16 b, input float16 r);
    if (a == F16_ZERO) return b;
    else if (b == F16_ZERO) return a;
    else return r;
  endfunction
`endif

endpackage

// File: rtl/fpu_fir_seq_coef.sv
// fpu_coef_bank: N_TAPS float16 coefficient registers, one write port and one
// combinational read port; out-of-range writes are dropped.
module fpu_coef_bank
  import fpu_fir_seq_pkg::*;
#(
  parameter int N_TAPS = 8,
  localparam int AW = $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  float16        wdata,
  input  logic [AW-1:0] raddr,
  output float16        rdata
);

  float16 coef [N_TAPS];

  // Coefficient storage with range-checked write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) coef[i] <= F16_ZERO;
    end else if (we && (int'(waddr) < N_TAPS)) begin
      coef[waddr] <= wdata;
    end
  end

  assign rdata = coef[raddr];

endmodule

// File: rtl/fpu_fir_seq.sv
// fpu_fir_seq: time-multiplexes a combinational float16 FPU into an N-tap FIR,
// one MULT or ADD per cycle. Optional exact-zero handling: FPU_FIR_ZERO_EN.
module fpu_fir_seq
  import fpu_fir_seq_pkg::*;
#(
  parameter int N_TAPS = 8,
  localparam int AW = $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  float16        in_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  float16        coef_data,
  output float16        fpu_a,
  output float16        fpu_b,
  output FPU_opcode     fpu_op,
  input  float16        fpu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output float16        out_data
);

  localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);

  fir_state_t    state;
  logic [AW-1:0] k;
  float16        acc;
  float16        prod;
  float16        x [N_TAPS];
  float16        coef_k;
  float16        mul_cap;
  float16        add_cap;

  fpu_coef_bank #(.N_TAPS(N_TAPS)) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_we),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (k),
    .rdata (coef_k)
  );

`ifdef FPU_FIR_ZERO_EN
  assign mul_cap = zero_mul(fpu_a, fpu_b, fpu_result);
  assign add_cap = zero_add(fpu_a, fpu_b, fpu_result);
`else
  assign mul_cap = fpu_result;
  assign add_cap = fpu_result;
`endif

  // FPU operand steering; idle states park the bus at 0, 0, ADD.
  always_comb begin
    fpu_a  = F16_ZERO;
    fpu_b  = F16_ZERO;
    fpu_op = ADD;
    case (state)
      ST_MUL: begin
        fpu_a  = coef_k;
        fpu_b  = x[k];
        fpu_op = MULT;
      end
      ST_ADD: begin
        fpu_a  = acc;
        fpu_b  = prod;
        fpu_op = ADD;
      end
      default: begin
        fpu_a  = F16_ZERO;
        fpu_b  = F16_ZERO;
        fpu_op = ADD;
      end
    endcase
  end

  // Sequencer: tap 0's product seeds acc directly, so no zero seed is ever added.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      acc   <= F16_ZERO;
      prod  <= F16_ZERO;
      for (int i = 0; i < N_TAPS; i++) x[i] <= F16_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x[0] <= in_sample;
            for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
            k     <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (k == '0) begin
            acc <= mul_cap;
            k   <= AW'(1);
          end else begin
            prod  <= mul_cap;
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          acc <= add_cap;
          if (k == K_LAST) begin
            state <= ST_DONE;
          end else begin
            k     <= k + AW'(1);
            state <= ST_MUL;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = acc;

endmodule

// File: tb/tb_fpu_fir_seq.sv
// Directed bench for fpu_fir_seq with a non-commutative stand-in FPU model,
// an operand-trace recorder and a golden tap-by-tap reference.
module tb_fpu_fir_seq;
  import fpu_fir_seq_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  float16     in_sample;
  logic       coef_we;
  logic [2:0] coef_addr;
  float16     coef_data;
  float16     fpu_a, fpu_b, fpu_result;
  FPU_opcode  fpu_op;
  logic       out_valid;
  logic       out_ready;
  float16     out_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] coef_m [N];
  logic [15:0] xh     [N];

  logic [15:0] tr_a  [1024];
  logic [15:0] tr_b  [1024];
  logic        tr_op [1024];
  int          ntrace = 0;

  fpu_fir_seq #(.N_TAPS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: MULT = 5a+b, ADD = 2a+b+1 (mod 2^16), deliberately non-commutative.
  function automatic logic [15:0] fmodel(input logic [15:0] a, input logic [15:0] b, input logic mul);
    if (mul) return (a * 16'd5) + b;
    else return (a << 1) + b + 16'd1;
  endfunction

  function automatic logic [15:0] cap_mul(input logic [15:0] a, input logic [15:0] b);
`ifdef FPU_FIR_ZERO_EN
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
`endif
    return fmodel(a, b, 1'b1);
  endfunction

  function automatic logic [15:0] cap_add(input logic [15:0] a, input logic [15:0] b);
`ifdef FPU_FIR_ZERO_EN
    if (a == 16'h0000) return b;
    if (b == 16'h0000) return a;
`endif
    return fmodel(a, b, 1'b0);
  endfunction

  assign fpu_result = fmodel(fpu_a, fpu_b, fpu_op == MULT);

  always @(negedge clk) begin
    if (!rst && !in_ready && !out_valid && ntrace < 1024) begin
      tr_a[ntrace]  = fpu_a;
      tr_b[ntrace]  = fpu_b;
      tr_op[ntrace] = (fpu_op == MULT);
      ntrace        = ntrace + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input logic [2:0] addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[addr] = data;
  endtask

  // Entered and left at a negedge with the DUT idle. Optional in-flight coef
  // write at cycle wcyc; hold cycles of backpressure, optionally with in_valid kept high.
  task automatic run_sample(input logic [15:0] s, input int wcyc, input logic [2:0] waddr,
                            input logic [15:0] wdata, input int hold, input logic keep_valid,
                            input logic [15:0] nxt);
    int cyc;
    int t0;
    logic [15:0] acc, p, od;
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1; in_sample = s;
    t0 = ntrace;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = N - 1; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = s;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      if (cyc == wcyc) begin
        coef_we = 1'b1; coef_addr = waddr; coef_data = wdata;
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      if (cyc == wcyc && int'(waddr) < N) coef_m[waddr] = wdata;
      cyc++;
    end
    coef_we = 1'b0;
    check("latency", cyc, 2 * N);
    check("ready_busy", in_ready, 0);
    check("trace_len", ntrace - t0, 2 * N - 1);
    acc = cap_mul(coef_m[0], xh[0]);
    check("mul0_op", tr_op[t0], 1);
    check("mul0_a", tr_a[t0], coef_m[0]);
    check("mul0_b", tr_b[t0], xh[0]);
    for (int k = 1; k < N; k++) begin
      p = cap_mul(coef_m[k], xh[k]);
      check("mul_op", tr_op[t0 + 2*k - 1], 1);
      check("mul_a",  tr_a[t0 + 2*k - 1], coef_m[k]);
      check("mul_b",  tr_b[t0 + 2*k - 1], xh[k]);
      check("add_op", tr_op[t0 + 2*k], 0);
      check("add_a",  tr_a[t0 + 2*k], acc);
      check("add_b",  tr_b[t0 + 2*k], p);
      acc = cap_add(acc, p);
    end
    check("out_data", out_data, acc);
    od = out_data;
    for (int h = 0; h < hold; h++) begin
      if (keep_valid) begin
        in_valid = 1'b1; in_sample = nxt;
      end
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, acc);
      check("bp_ready", in_ready, 0);
    end
    check("done_fpu_op", fpu_op, ADD);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("release_data", out_data, od);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sample = 16'h0000; coef_we = 1'b0;
    coef_addr = 3'd0; coef_data = 16'h0000; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin coef_m[i] = 16'h0000; xh[i] = 16'h0000; end
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_fpu_a", fpu_a, 16'h0000);
    check("rst_fpu_b", fpu_b, 16'h0000);
    check("rst_fpu_op", fpu_op, ADD);
    rst = 1'b0;
    @(negedge clk);

    // Unity coefficients, single sample.
    for (int k = 0; k < N; k++) wr_coef(3'(k), 16'h3C00);
    run_sample(16'h4000, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);

    // Distinct coefficients, delay-line shifting, backpressure with in_valid held.
    for (int k = 0; k < N; k++) wr_coef(3'(k), 16'h3C00 + 16'(k));
    run_sample(16'h4100, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);
    run_sample(16'h4200, 0, 3'd0, 16'h0000, 10, 1'b1, 16'h4300);
    run_sample(16'h4300, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);

    // Reset in the middle of ADD at cycle 5.
    in_valid = 1'b1; in_sample = 16'h4500;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_is_add", fpu_op, ADD);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_data", out_data, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin coef_m[i] = 16'h0000; xh[i] = 16'h0000; end
    repeat (3) @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    // Zero coefs and zero history must show up in the operand trace.
    run_sample(16'h4600, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);

    // In-flight coefficient write to tap 6 at cycle 3.
    for (int k = 0; k < N; k++) wr_coef(3'(k), 16'h3C00 + 16'(k));
    run_sample(16'h4700, 3, 3'd6, 16'h4400, 0, 1'b0, 16'h0000);
    check("coef6_model", coef_m[6], 16'h4400);

    // Zero sample lands in x[3]; exact-zero handling depends on FPU_FIR_ZERO_EN.
    run_sample(16'h0000, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);
    run_sample(16'h3800, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);
    run_sample(16'h3A00, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);
    run_sample(16'h3E00, 0, 3'd0, 16'h0000, 0, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
